// File: rtl/obi_resp_pkg.sv
// Shared types and constants for the OBI SRAM responder: FSM state encoding,
// integrity inversion mask and wait-counter width.
package obi_resp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } obi_state_e;

    localparam logic [6:0] INTG_INV_MASK = 7'h2A;
    localparam int unsigned WAIT_CNT_W   = 4;

endpackage

// File: rtl/obi_resp_intg_enc.sv
// Combinational inverted Hsiao SECDED(39,32) encoder: 32 data bits in,
// 7 check bits out (XORed with the inversion mask so all-zero data is not all-zero code).
module obi_resp_intg_enc
    import obi_resp_pkg::*;
(
    input  logic [31:0] data,
    output logic [6:0]  intg
);

    assign intg = {^(data & 32'h9850_5586),
                   ^(data & 32'h2DCC_624C),
                   ^(data & 32'hC2C1_323B),
                   ^(data & 32'h3123_4ED1),
                   ^(data & 32'h413D_89AA),
                   ^(data & 32'hDEBA_8050),
                   ^(data & 32'h2606_BD25)} ^ INTG_INV_MASK;

endmodule

// File: rtl/obi_sram_resp.sv
// OBI memory-side responder: word RAM with byte enables, wait states before grant,
// range errors, and optional bus integrity (enabled by defining OBI_RESP_INTG_EN).
//
//  state | meaning
//  IDLE  | no request pending; grants at once when WAIT_STATES = 0
//  WAIT  | request seen, counting wait states down to the grant
module obi_sram_resp
    import obi_resp_pkg::*;
#(
    parameter int unsigned AW_WORDS    = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o
);

    localparam int unsigned DEPTH = 2 ** AW_WORDS;
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

    obi_state_e            state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  gnt;

    always_comb begin
        gnt = 1'b0;
        unique case (state_q)
            IDLE:    gnt = req_i && (WAIT_STATES == 0);
            WAIT:    gnt = req_i && (cnt_q == '0);
            default: gnt = 1'b0;
        endcase
    end

    // After every grant the FSM returns to IDLE, so a held request reloads the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i && (WAIT_STATES != 0)) begin
                        state_q <= WAIT;
                        cnt_q   <= WS_LOAD;
                    end
                end
                WAIT: begin
                    if (!req_i || (cnt_q == '0)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o = gnt;

    // Word-granular decode; BASE_ADDR is aligned to the memory size.
    logic [29:0]         word_off;
    logic                in_range;
    logic [AW_WORDS-1:0] idx;

    assign word_off = addr_i[31:2] - BASE_ADDR[31:2];
    assign in_range = (addr_i[31:2] >= BASE_ADDR[31:2]) && (word_off[29:AW_WORDS] == '0);
    assign idx      = word_off[AW_WORDS-1:0];

    logic        intg_err;
    logic [31:0] rdata_q;

`ifdef OBI_RESP_INTG_EN
    logic [6:0] wdata_intg_exp;
    logic [6:0] rdata_intg;

    obi_resp_intg_enc u_wdata_enc (
        .data (wdata_i),
        .intg (wdata_intg_exp)
    );

    obi_resp_intg_enc u_rdata_enc (
        .data (rdata_q),
        .intg (rdata_intg)
    );

    assign intg_err     = we_i && (wdata_intg_exp != wdata_intg_i);
    assign rdata_intg_o = rdata_intg;
`else
    logic unused_intg;

    assign unused_intg  = ^wdata_intg_i;
    assign intg_err     = 1'b0;
    assign rdata_intg_o = '0;
`endif

    logic unused_addr;
    assign unused_addr = ^addr_i[1:0];

    logic acc_err;
    logic do_write;

    assign acc_err  = !in_range || intg_err;
    assign do_write = gnt && we_i && !acc_err;

    logic [31:0] mem [DEPTH];

    // Storage is deliberately left out of reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    logic rvalid_q;
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt && acc_err;
            if (gnt && !we_i) rdata_q <= in_range ? mem[idx] : '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule
